// File: rtl/lsu_pkg.sv
// Shared types and size helpers for the RV64 load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef logic [3:0] size_t;

    // Access width in bytes; zero marks the illegal encoding.
    function automatic size_t size_bytes(input logic [2:0] funct3);
        size_t n;
        case (funct3)
            F3_B, F3_BU: n = 4'd1;
            F3_H, F3_HU: n = 4'd2;
            F3_W, F3_WU: n = 4'd4;
            F3_D:        n = 4'd8;
            default:     n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: extracts and extends a load field, or merges store bytes into a doubleword.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        do_merge,
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] old_word,
    input  logic [63:0] new_data,
    output logic [63:0] result
);

    logic [63:0] field_s;
    logic [63:0] placed_s;
    logic [7:0]  lane_mask_s;

    assign field_s     = old_word >> {off, 3'b000};
    assign placed_s    = new_data << {off, 3'b000};
    assign lane_mask_s = 8'((16'd1 << size_bytes(funct3)) - 16'd1) << off;

    // Merge replaces only the lanes covered by the access; extract shifts down and extends.
    always_comb begin
        result = 64'd0;
        if (do_merge) begin
            for (int i = 0; i < 8; i++) begin
                if (lane_mask_s[i]) begin
                    result[8*i +: 8] = placed_s[8*i +: 8];
                end else begin
                    result[8*i +: 8] = old_word[8*i +: 8];
                end
            end
        end else begin
            case (funct3)
                F3_B:    result = {{56{field_s[7]}}, field_s[7:0]};
                F3_H:    result = {{48{field_s[15]}}, field_s[15:0]};
                F3_W:    result = {{32{field_s[31]}}, field_s[31:0]};
                F3_BU:   result = {56'd0, field_s[7:0]};
                F3_HU:   result = {48'd0, field_s[15:0]};
                F3_WU:   result = {32'd0, field_s[31:0]};
                default: result = field_s;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV64 data-memory stage: sized loads, read-modify-write partial stores, fault detection.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [63:0] load_data,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    localparam logic [7:0] LAT_M1 = 8'(RD_LATENCY - 1);

    lsu_state_t  state_r, state_next_s;
    logic [7:0]  cnt_r;
    logic        is_store_r;
    logic [2:0]  funct3_r;
    logic [2:0]  off_r;
    logic [63:0] store_data_r;
    logic        busy_r, done_r, fault_r, mem_wr_r;
    logic [63:0] load_data_r, mem_addr_r, mem_wdata_r;
    logic        illegal_s, misaligned_s, req_fault_s, store_d_s, accept_s, rd_last_s;
    logic [63:0] load_ext_s, merge_s;

    // Both align paths see the read data on the capture cycle, so results land on the RD exit edge.
    lsu_align u_load_align (
        .do_merge (1'b0),
        .funct3   (funct3_r),
        .off      (off_r),
        .old_word (mem_rdata),
        .new_data (64'd0),
        .result   (load_ext_s)
    );

    lsu_align u_store_align (
        .do_merge (1'b1),
        .funct3   (funct3_r),
        .off      (off_r),
        .old_word (mem_rdata),
        .new_data (store_data_r),
        .result   (merge_s)
    );

    // Classify the incoming request before it is accepted.
    always_comb begin
        illegal_s    = (funct3 == 3'b111) || (is_store && funct3[2]);
        misaligned_s = (addr[2:0] & 3'(size_bytes(funct3) - 4'd1)) != 3'd0;
        req_fault_s  = illegal_s || misaligned_s;
        store_d_s    = is_store && (funct3 == F3_D);
        accept_s     = (state_r == IDLE) && start;
        rd_last_s    = (state_r == RD) && (cnt_r == 8'd0);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!start) begin
                    state_next_s = IDLE;
                end else if (req_fault_s) begin
                    state_next_s = DONE;
                end else if (store_d_s) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RD;
                end
            end
            RD: begin
                if (!rd_last_s) begin
                    state_next_s = RD;
                end else if (is_store_r) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = DONE;
                end
            end
            WR:      state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs, request latches and read-latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r        <= 8'd0;
            is_store_r   <= 1'b0;
            funct3_r     <= 3'd0;
            off_r        <= 3'd0;
            store_data_r <= 64'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            mem_wr_r     <= 1'b0;
            load_data_r  <= 64'd0;
            mem_addr_r   <= 64'd0;
            mem_wdata_r  <= 64'd0;
        end else begin
            busy_r   <= (state_next_s != IDLE);
            done_r   <= (state_next_s == DONE);
            mem_wr_r <= (state_next_s == WR);
            fault_r  <= accept_s && req_fault_s;
            if (accept_s) begin
                is_store_r   <= is_store;
                funct3_r     <= funct3;
                off_r        <= addr[2:0];
                store_data_r <= store_data;
                mem_addr_r   <= {addr[63:3], 3'b000};
                cnt_r        <= LAT_M1;
                if (store_d_s && !req_fault_s) begin
                    mem_wdata_r <= store_data;
                end
            end else if (state_r == RD) begin
                if (rd_last_s) begin
                    if (is_store_r) begin
                        mem_wdata_r <= merge_s;
                    end else begin
                        load_data_r <= load_ext_s;
                    end
                end else begin
                    cnt_r <= cnt_r - 8'd1;
                end
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign fault     = fault_r;
    assign mem_wr    = mem_wr_r;
    assign load_data = load_data_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-level reference model and per-cycle output compare.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] store_data = 64'd0;
    logic        busy, done, fault, mem_wr;
    logic [63:0] load_data, mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    bit          chk_on = 1'b0;
    int          t0 = -1000;
    int          n_lat = 0;
    bit          exp_wr = 1'b0;
    bit          exp_fault = 1'b0;
    logic [63:0] exp_addr = 64'd0;
    logic [63:0] exp_wdata = 64'd0;
    logic [63:0] ld_prev = 64'd0;
    logic [63:0] ld_new = 64'd0;
    logic [63:0] ref_mem [16];

    logic [63:0] mem [16];
    logic [63:0] dly [LAT-1];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [63:0] pl_val = 64'd0;
    logic [3:0]  mem_idx;

    always #5 clk = ~clk;

    load_store_unit #(.RD_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata)
    );

    // Data memory with LAT cycles from a stable address to valid read data.
    assign mem_idx   = mem_addr[6:3];
    assign mem_rdata = dly[LAT-2];
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        dly[0] <= mem[mem_idx];
        for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_wr) mem[mem_idx] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {63'd0, act}, {63'd0, exp});
    endtask

    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 4;
            3'b011:         return 8;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] w, input logic [2:0] f3, input int off);
        logic [7:0]  b [8];
        logic [63:0] v;
        int n;
        n = m_size(f3);
        v = 64'd0;
        for (int i = 0; i < 8; i++) b[i] = w[8*i +: 8];
        for (int i = 0; i < n; i++) v[8*i +: 8] = b[off + i];
        if (!f3[2] && n < 8 && b[off + n - 1][7])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] m_store(input logic [63:0] w, input logic [63:0] d,
                                            input logic [2:0] f3, input int off);
        logic [63:0] v;
        v = w;
        for (int i = 0; i < m_size(f3); i++) v[8*(off + i) +: 8] = d[8*i +: 8];
        return v;
    endfunction

    // Per-cycle compare of DUT outputs against the transaction model.
    always @(negedge clk) begin
        int rel;
        if (chk_on) begin
            rel = cyc - t0;
            chk1("busy", busy, rel >= 1 && rel <= n_lat);
            chk1("done", done, rel == n_lat);
            chk1("mem_wr", mem_wr, exp_wr && rel == n_lat - 1);
            chk("load_data", load_data, (rel >= n_lat) ? ld_new : ld_prev);
            if (rel == n_lat) chk1("fault", fault, exp_fault);
            if (rel >= 1 && rel <= n_lat) chk("mem_addr", mem_addr, exp_addr);
            if (exp_wr && rel == n_lat - 1) chk("mem_wdata", mem_wdata, exp_wdata);
        end
    end

    // One transaction; rp_rel re-pulses start at that relative cycle, rst_rel resets there.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input int lat_lit, input int rp_rel, input int rst_rel);
        int n, off, idx, lat;
        bit flt, seen, was_rst;
        logic [63:0] old;
        n   = m_size(f3);
        off = int'(a[2:0]);
        idx = int'(a[6:3]);
        flt = (n == 0) ? 1'b1 : ((st && f3[2]) || ((off % n) != 0));
        old = ref_mem[idx];
        exp_fault = flt;
        exp_addr  = {a[63:3], 3'b000};
        exp_wr    = st && !flt;
        n_lat     = flt ? 1 : (!st ? LAT + 1 : ((f3 == 3'b011) ? 2 : LAT + 2));
        ld_prev   = ld_new;
        if (!st && !flt) ld_new = m_load(old, f3, off);
        if (exp_wr) begin
            exp_wdata   = m_store(old, d, f3, off);
            ref_mem[idx] = exp_wdata;
        end
        t0 = cyc;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        seen = 1'b0; was_rst = 1'b0; lat = -1;
        for (int k = 1; k <= 20 && !seen && !was_rst; k++) begin
            @(posedge clk); #2;
            start = (k == rp_rel);
            if (k == rp_rel) begin
                is_store = 1'b1; funct3 = 3'b011; addr = 64'h40; store_data = 64'h0BAD_0BAD_0BAD_0BAD;
            end
            if (k == rst_rel) begin
                chk_on = 1'b0;
                rst = 1'b0;
                #1;
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_mem_wr", mem_wr, 1'b0);
                chk1("rst_done", done, 1'b0);
                repeat (2) begin
                    @(posedge clk); #2;
                    chk1("rst_hold_mem_wr", mem_wr, 1'b0);
                end
                rst = 1'b1;
                if (exp_wr) ref_mem[idx] = old;
                ld_prev = 64'd0; ld_new = 64'd0; t0 = -1000; n_lat = 0; exp_wr = 1'b0;
                chk_on = 1'b1;
                was_rst = 1'b1;
            end else if (done) begin
                seen = 1'b1;
                lat = k;
            end
        end
        if (!was_rst) chk("latency", 64'(lat), 64'(lat_lit));
        @(posedge clk); #2;
        start = 1'b0;
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            pl_en  = 1'b1;
            pl_idx = 4'(i);
            pl_val = (i == 0) ? 64'h1122_3344_5566_8877 :
                     (i == 2) ? 64'd0 : 64'h0F1E_2D3C_4B5A_6978 + 64'(i);
            ref_mem[i] = pl_val;
            @(posedge clk); #2;
        end
        pl_en = 1'b0;

        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_fault", fault, 1'b0);
        chk1("reset_mem_wr", mem_wr, 1'b0);
        chk("reset_load_data", load_data, 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_mem_wdata", mem_wdata, 64'd0);
        rst = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #2;

        // Byte loads: lane k of 0x1122334455668877 is byte k counted from the LSB.
        do_op(1'b0, 3'b000, 64'h03, 64'd0, 4, 0, 0);
        chk("lb_off3", load_data, 64'h0000_0000_0000_0055);
        do_op(1'b0, 3'b000, 64'h02, 64'd0, 4, 0, 0);
        chk("lb_off2", load_data, 64'h0000_0000_0000_0066);
        do_op(1'b0, 3'b000, 64'h01, 64'd0, 4, 0, 0);
        chk("lb_off1", load_data, 64'hFFFF_FFFF_FFFF_FF88);
        do_op(1'b0, 3'b100, 64'h01, 64'd0, 4, 0, 0);
        chk("lbu_off1", load_data, 64'h0000_0000_0000_0088);
        do_op(1'b0, 3'b011, 64'h00, 64'd0, 4, 0, 0);
        chk("ld", load_data, 64'h1122_3344_5566_8877);

        do_op(1'b1, 3'b001, 64'h12, 64'h0000_0000_0000_BEEF, 5, 0, 0);
        chk("sh_mem", mem[2], 64'h0000_0000_BEEF_0000);
        do_op(1'b1, 3'b011, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 2, 0, 0);
        chk("sd_mem", mem[4], 64'hDEAD_BEEF_CAFE_F00D);

        do_op(1'b0, 3'b001, 64'h12, 64'd0, 4, 0, 0);
        chk("lh", load_data, 64'hFFFF_FFFF_FFFF_BEEF);
        do_op(1'b0, 3'b101, 64'h12, 64'd0, 4, 0, 0);
        chk("lhu", load_data, 64'h0000_0000_0000_BEEF);
        do_op(1'b0, 3'b010, 64'h10, 64'd0, 4, 0, 0);
        chk("lw", load_data, 64'hFFFF_FFFF_BEEF_0000);
        do_op(1'b0, 3'b110, 64'h10, 64'd0, 4, 0, 0);
        chk("lwu", load_data, 64'h0000_0000_BEEF_0000);

        do_op(1'b1, 3'b010, 64'h24, 64'h0000_0000_1234_5678, 5, 0, 0);
        chk("sw_hi_mem", mem[4], 64'h1234_5678_CAFE_F00D);
        do_op(1'b1, 3'b000, 64'h27, 64'h0000_0000_0000_0099, 5, 0, 0);
        chk("sb_lane7_mem", mem[4], 64'h9934_5678_CAFE_F00D);

        // Faults: misaligned LW and SD, illegal funct3, store with unsigned code.
        do_op(1'b0, 3'b010, 64'h06, 64'd0, 1, 0, 0);
        do_op(1'b1, 3'b011, 64'h09, 64'h1111_2222_3333_4444, 1, 0, 0);
        do_op(1'b0, 3'b111, 64'h00, 64'd0, 1, 0, 0);
        do_op(1'b1, 3'b100, 64'h00, 64'h0000_0000_0000_0077, 1, 0, 0);
        chk("fault_keeps_load_data", load_data, 64'h0000_0000_BEEF_0000);
        chk("fault_no_write", mem[1], 64'h0F1E_2D3C_4B5A_6979);

        // Start re-pulsed mid-read and in the done cycle is ignored.
        do_op(1'b0, 3'b010, 64'h10, 64'd0, 4, 2, 0);
        do_op(1'b0, 3'b110, 64'h14, 64'd0, 4, 4, 0);
        chk("repulse_lwu_hi", load_data, 64'h0000_0000_0000_0000);
        chk("repulse_no_sd", mem[8], 64'h0F1E_2D3C_4B5A_6980);

        // Reset in the cycle before the write of a partial store.
        do_op(1'b1, 3'b000, 64'h31, 64'h0000_0000_0000_00AA, 0, 0, LAT);
        chk("post_rst_load_data", load_data, 64'd0);
        chk("post_rst_mem", mem[6], 64'h0F1E_2D3C_4B5A_697E);
        do_op(1'b0, 3'b011, 64'h20, 64'd0, 4, 0, 0);
        chk("recover_ld", load_data, 64'h9934_5678_CAFE_F00D);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
